ddr4_fine_sweep: RTL and testbench
==================================

// Module: ddr4_fine_sweep
// PURPOSE
//  Per-lane fine read-DQS delay sweep engine for the DDR4 PHY training path; sits under ddr4_fsm,
//  launched by fine_start once a coarse region is picked. Steps the delay tap across a span,
//  issues test reads, and tracks the widest passing eye per lane. Returns fine_done/fine_failed
//  plus per-lane best_start/best_end/best_width/lane_valid.
// PARAMETERS
//  LANES        16   number of byte/DQS lanes
//  DELAY_TAPS   64   delay line taps; TAPW=$clog2(DELAY_TAPS), WW=$clog2(DELAY_TAPS+1)
//  COARSE_STEPS 8    coarse regions; STEP=DELAY_TAPS/COARSE_STEPS
//  SPAN         32   taps swept per run, starting at the coarse base
//  SAMPLES      4    test reads per tap; a tap passes only if all SAMPLES pass
//  SETTLE       2    idle cycles after each tap change, before the first read
//  MIN_WIDTH    6    minimum eye width (taps) for lane_valid
//  TIMEOUT      256  max cycles spent in READ_WAIT before the sweep aborts
// PORTS
//  clk          in   1              single clock, all logic on posedge
//  rst          in   1              asynchronous reset, active-high
//  fine_start   in   1              start pulse; sampled only in IDLE, ignored otherwise
//  coarse_sel   in   $clog2(CS)     coarse region; base = coarse_sel*STEP
//  read_ok      in   LANES          per-lane compare result, qualified by read_valid
//  read_valid   in   1              test-read result strobe
//  delay_tap    out  TAPW           tap driven to the delay lines
//  read_req     out  1              one-cycle pulse requesting one test read
//  busy         out  1              high in every state except IDLE
//  fine_done    out  1              one-cycle pulse: sweep ended, all lanes valid
//  fine_failed  out  1              one-cycle pulse: any lane invalid, or timeout
//  lane_valid   out  LANES          best_width[l] >= MIN_WIDTH
//  best_start   out  LANES*TAPW     flat, lane l at [l*TAPW +: TAPW]
//  best_end     out  LANES*TAPW     flat; equals best_start+best_width-1, or 0 if width 0
//  best_width   out  LANES*WW       flat; 0 means no passing tap
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all trackers cleared. Reset asserted mid-sweep aborts
//   immediately and emits no done/failed pulse.
//  States: IDLE, SETTLE, READ_REQ, READ_WAIT, EVAL, FINISH, REPORT.
//  IDLE: on fine_start, latch base and last = min(base+SPAN-1, DELAY_TAPS-1).
//   Same edge: delay_tap<=base; clear best_*, lane_valid and run trackers; pass_acc<=all 1s;
//   sample count<=0. Go to SETTLE.
//  SETTLE: stay SETTLE cycles, then go to READ_REQ.
//  READ_REQ: read_req=1 for exactly this one cycle, reset the timeout counter, go to READ_WAIT.
//  READ_WAIT on read_valid: pass_acc &= read_ok; count++.
//   If count==SAMPLES go to EVAL, else go to READ_REQ.
//   read_valid in any other state is ignored.
//  READ_WAIT timeout: after TIMEOUT cycles with no read_valid, clear lane_valid and best_*,
//   pulse fine_failed, go to IDLE.
//  EVAL, per lane:
//   - Pass: if no run is open, open one (run_start=tap, run_len=1); else run_len++.
//   - Fail: close any open run. A closed run replaces best only if run_len > best_width.
//     Ties keep the earlier window.
//   - Then: if tap==last go to FINISH; else tap++, reset pass_acc and count, go to SETTLE.
//  FINISH: close all open runs with the same rule. Set lane_valid. Go to REPORT.
//  REPORT: pulse fine_done if lane_valid is all 1s, else fine_failed. Exactly one pulse per
//   sweep. Go to IDLE.
//  Hold: best_*, lane_valid and delay_tap hold until the next fine_start.
//  Arithmetic: run_len saturates at WW bits (never exceeds SPAN). Tap never wraps past
//   DELAY_TAPS-1.
//  fine_start while busy is dropped; no queueing.
//  Per-tap cycle count = 1 + SETTLE + SAMPLES*(1 + read latency).
// TESTING
//  1 coarse_sel=2, all lanes pass taps 20..33 -> sweep 16..47; every lane start=20, end=33,
//    width=14; lane_valid=16'hFFFF; single fine_done pulse.
//  2 lane3 passes 18..22 and 30..39 -> start=30, end=39, width=10.
//    lane5 passes 17..22 and 26..31 (tie) -> start=17.
//  3 lane0 never passes -> lane0 width=0, start=0, end=0, lane_valid[0]=0; fine_failed pulse,
//    fine_done stays 0.
//  4 lane1, tap 25: one of 4 samples fails inside window 20..33 -> tap 25 rejected;
//    best = 26..33, width=8.
//  5 coarse_sel=7, window 60..63 -> sweep clamps at 63; run closed in FINISH; width=4 <6;
//    fine_failed.
//  6 hold read_valid low 256 cycles -> fine_failed, lane_valid=0.
//    rst mid-sweep -> outputs 0, no pulses.
//    fine_start while busy -> no effect.

Source files
------------

// File: rtl/ddr4_fine_sweep_if.sv
// Handshake and result bundle between the DDR4 training sequencer and the fine DQS sweep engine.
interface ddr4_fine_sweep_if #(
  parameter int LANES = 16,
  parameter int TAPW  = 6,
  parameter int WW    = 7,
  parameter int CSW   = 3
);
  logic                  fine_start;
  logic [CSW-1:0]        coarse_sel;
  logic [LANES-1:0]      read_ok;
  logic                  read_valid;
  logic [TAPW-1:0]       delay_tap;
  logic                  read_req;
  logic                  busy;
  logic                  fine_done;
  logic                  fine_failed;
  logic [LANES-1:0]      lane_valid;
  logic [LANES*TAPW-1:0] best_start;
  logic [LANES*TAPW-1:0] best_end;
  logic [LANES*WW-1:0]   best_width;

  modport master (
    output fine_start, coarse_sel, read_ok, read_valid,
    input  delay_tap, read_req, busy, fine_done, fine_failed,
    input  lane_valid, best_start, best_end, best_width
  );

  modport slave (
    input  fine_start, coarse_sel, read_ok, read_valid,
    output delay_tap, read_req, busy, fine_done, fine_failed,
    output lane_valid, best_start, best_end, best_width
  );
endinterface

// File: rtl/ddr4_fine_sweep.sv
// Fine read-DQS sweep: steps the tap across a span from the coarse base, issues SAMPLES reads
// per tap and keeps the widest fully-passing window per lane (earliest window wins ties).
module ddr4_fine_sweep #(
  parameter int LANES        = 16,
  parameter int DELAY_TAPS   = 64,
  parameter int COARSE_STEPS = 8,
  parameter int SPAN         = 32,
  parameter int SAMPLES      = 4,
  parameter int SETTLE       = 2,
  parameter int MIN_WIDTH    = 6,
  parameter int TIMEOUT      = 256
) (
  input logic              clk,
  input logic              rst,
  ddr4_fine_sweep_if.slave sw
);
  localparam int TAPW  = $clog2(DELAY_TAPS);
  localparam int WW    = $clog2(DELAY_TAPS + 1);
  localparam int STEP  = DELAY_TAPS / COARSE_STEPS;
  localparam int SCW   = $clog2(SETTLE + 1);
  localparam int SMW   = $clog2(SAMPLES + 1);
  localparam int TOW   = $clog2(TIMEOUT + 1);
  localparam int LASTW = TAPW + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_RREQ   = 3'd2;
  localparam logic [2:0] S_RWAIT  = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  logic [2:0]       r_state;
  logic [TAPW-1:0]  r_tap;
  logic [TAPW-1:0]  r_last;
  logic [SCW-1:0]   r_settle;
  logic [SMW-1:0]   r_cnt;
  logic [TOW-1:0]   r_to;
  logic [LANES-1:0] r_pass_acc;
  logic [LANES-1:0] r_run_open;
  logic [LANES-1:0] r_lane_valid;
  logic             r_done;
  logic             r_failed;
  logic [TAPW-1:0]  r_run_start  [LANES];
  logic [WW-1:0]    r_run_len    [LANES];
  logic [TAPW-1:0]  r_best_start [LANES];
  logic [WW-1:0]    r_best_width [LANES];

  logic [LASTW-1:0] w_base_x;
  logic [LASTW-1:0] w_last_x;
  logic [TAPW-1:0]  w_last;
  logic [TAPW-1:0]  w_close_start [LANES];
  logic [WW-1:0]    w_close_width [LANES];

  // Sweep end clamps to the last physical tap so the delay line never wraps.
  assign w_base_x = LASTW'(sw.coarse_sel) * LASTW'(STEP);
  assign w_last_x = w_base_x + LASTW'(SPAN - 1);
  assign w_last   = (w_last_x > LASTW'(DELAY_TAPS - 1)) ? TAPW'(DELAY_TAPS - 1)
                                                        : w_last_x[TAPW-1:0];

  // Best window after closing the open run; strict '>' keeps the earlier window on a tie.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_close_start[l] = r_best_start[l];
      w_close_width[l] = r_best_width[l];
      if (r_run_open[l] && (r_run_len[l] > r_best_width[l])) begin
        w_close_start[l] = r_run_start[l];
        w_close_width[l] = r_run_len[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tap        <= '0;
      r_last       <= '0;
      r_settle     <= '0;
      r_cnt        <= '0;
      r_to         <= '0;
      r_pass_acc   <= '0;
      r_run_open   <= '0;
      r_lane_valid <= '0;
      r_done       <= 1'b0;
      r_failed     <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_run_start[l]  <= '0;
        r_run_len[l]    <= '0;
        r_best_start[l] <= '0;
        r_best_width[l] <= '0;
      end
    end else begin
      r_done   <= 1'b0;
      r_failed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sw.fine_start) begin
            r_tap        <= w_base_x[TAPW-1:0];
            r_last       <= w_last;
            r_pass_acc   <= '1;
            r_cnt        <= '0;
            r_settle     <= '0;
            r_run_open   <= '0;
            r_lane_valid <= '0;
            for (int l = 0; l < LANES; l++) begin
              r_run_start[l]  <= '0;
              r_run_len[l]    <= '0;
              r_best_start[l] <= '0;
              r_best_width[l] <= '0;
            end
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle == SCW'(SETTLE - 1)) begin
            r_settle <= '0;
            r_state  <= S_RREQ;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_RREQ: begin
          r_to    <= '0;
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (sw.read_valid) begin
            r_pass_acc <= r_pass_acc & sw.read_ok;
            r_cnt      <= r_cnt + 1'b1;
            r_state    <= (r_cnt == SMW'(SAMPLES - 1)) ? S_EVAL : S_RREQ;
          end else if (r_to == TOW'(TIMEOUT - 1)) begin
            // Dead read path: abort with nothing reported as valid.
            r_lane_valid <= '0;
            r_run_open   <= '0;
            for (int l = 0; l < LANES; l++) begin
              r_best_start[l] <= '0;
              r_best_width[l] <= '0;
            end
            r_failed <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        S_EVAL: begin
          for (int l = 0; l < LANES; l++) begin
            if (r_pass_acc[l]) begin
              if (!r_run_open[l]) begin
                r_run_open[l]  <= 1'b1;
                r_run_start[l] <= r_tap;
                r_run_len[l]   <= WW'(1);
              end else if (r_run_len[l] != '1) begin
                r_run_len[l] <= r_run_len[l] + 1'b1;
              end
            end else begin
              r_best_start[l] <= w_close_start[l];
              r_best_width[l] <= w_close_width[l];
              r_run_open[l]   <= 1'b0;
            end
          end
          if (r_tap == r_last) begin
            r_state <= S_FINISH;
          end else begin
            r_tap      <= r_tap + 1'b1;
            r_pass_acc <= '1;
            r_cnt      <= '0;
            r_settle   <= '0;
            r_state    <= S_SETTLE;
          end
        end
        S_FINISH: begin
          for (int l = 0; l < LANES; l++) begin
            r_best_start[l] <= w_close_start[l];
            r_best_width[l] <= w_close_width[l];
            r_lane_valid[l] <= (w_close_width[l] >= WW'(MIN_WIDTH));
          end
          r_run_open <= '0;
          r_state    <= S_REPORT;
        end
        S_REPORT: begin
          r_done   <= &r_lane_valid;
          r_failed <= ~&r_lane_valid;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sw.delay_tap   = r_tap;
  assign sw.read_req    = (r_state == S_RREQ);
  assign sw.busy        = (r_state != S_IDLE);
  assign sw.fine_done   = r_done;
  assign sw.fine_failed = r_failed;
  assign sw.lane_valid  = r_lane_valid;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign sw.best_start[g*TAPW +: TAPW] = r_best_start[g];
    assign sw.best_width[g*WW +: WW]     = r_best_width[g];
    assign sw.best_end[g*TAPW +: TAPW]   = (r_best_width[g] == '0) ? '0 :
        r_best_start[g] + TAPW'(r_best_width[g]) - TAPW'(1);
  end
endmodule

// File: tb/tb_ddr4_fine_sweep.sv
// Scoreboard bench for ddr4_fine_sweep: a responder answers read_req from per-mode pass tables,
// expected results are queued per sweep and checked when the done/failed pulse appears.
module tb_ddr4_fine_sweep;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr4_fine_sweep_if #(.LANES(16), .TAPW(6), .WW(7), .CSW(3)) ifc ();
  ddr4_fine_sweep dut (.clk(clk), .rst(rst), .sw(ifc));

  typedef struct packed {
    logic             done;
    logic             failed;
    logic [15:0]      lv;
    logic [5:0]       tap;
    logic [15:0][5:0] s;
    logic [15:0][5:0] e;
    logic [15:0][6:0] w;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_pulses = 0;
  int   mode     = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t uni(input int s, input int e, input int w,
                               input logic [15:0] lv, input logic [5:0] tap);
    exp_t x;
    x.lv     = lv;
    x.done   = (lv == 16'hFFFF);
    x.failed = (lv != 16'hFFFF);
    x.tap    = tap;
    for (int l = 0; l < 16; l++) begin
      x.s[l] = 6'(s);
      x.e[l] = 6'(e);
      x.w[l] = 7'(w);
    end
    return x;
  endfunction

  function automatic logic [15:0] ok_vec(input int m, input int tap, input int smp);
    logic [15:0] v;
    v = (tap >= 20 && tap <= 33) ? 16'hFFFF : 16'h0000;
    case (m)
      2: begin
        v[3] = (tap >= 18 && tap <= 22) || (tap >= 30 && tap <= 39);
        v[5] = (tap >= 17 && tap <= 22) || (tap >= 26 && tap <= 31);
      end
      3: v[0] = 1'b0;
      4: if (tap == 25 && smp == 2) v[1] = 1'b0;
      5: v = (tap >= 60) ? 16'hFFFF : 16'h0000;
      default: ;
    endcase
    return v;
  endfunction

  // Responder: one-cycle read latency; mode 6 never answers.
  initial begin
    int smp;
    int last_tap;
    smp = 0;
    last_tap = -1;
    ifc.read_valid = 1'b0;
    ifc.read_ok    = '0;
    forever begin
      @(negedge clk);
      ifc.read_valid = 1'b0;
      if (!rst && ifc.read_req && mode != 6) begin
        if (int'(ifc.delay_tap) != last_tap) begin
          last_tap = int'(ifc.delay_tap);
          smp = 0;
        end
        @(negedge clk);
        ifc.read_ok    = ok_vec(mode, last_tap, smp);
        ifc.read_valid = 1'b1;
        smp++;
      end
    end
  end

  // Monitor: every done/failed pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (ifc.fine_done || ifc.fine_failed)) begin
        n_pulses++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", {ifc.fine_done, ifc.fine_failed}, 0);
        end else begin
          e = q.pop_front();
          chk("fine_done",  ifc.fine_done,   e.done);
          chk("fine_failed", ifc.fine_failed, e.failed);
          chk("lane_valid", ifc.lane_valid,  e.lv);
          chk("delay_tap",  ifc.delay_tap,   e.tap);
          chk("best_start", ifc.best_start,  e.s);
          chk("best_end",   ifc.best_end,    e.e);
          chk("best_width", ifc.best_width,  e.w);
        end
      end
    end
  end

  task automatic run_sweep(input int m, input int cs, input exp_t x, input int poke);
    int target;
    int cyc;
    mode = m;
    q.push_back(x);
    target = n_pulses + 1;
    @(negedge clk);
    ifc.coarse_sel = 3'(cs);
    ifc.fine_start = 1'b1;
    @(negedge clk);
    ifc.fine_start = 1'b0;
    chk("busy_after_start", ifc.busy, 1);
    cyc = 0;
    while (n_pulses < target && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (poke > 0 && cyc == poke) begin
        ifc.coarse_sel = 3'd7;
        ifc.fine_start = 1'b1;
      end else begin
        ifc.fine_start = 1'b0;
      end
    end
    ifc.fine_start = 1'b0;
    if (n_pulses < target) begin
      chk("sweep_timeout", n_pulses, target);
      q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    exp_t x;
    rst = 1'b1;
    ifc.fine_start = 1'b0;
    ifc.coarse_sel = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",       ifc.busy,       0);
    chk("rst_read_req",   ifc.read_req,   0);
    chk("rst_delay_tap",  ifc.delay_tap,  0);
    chk("rst_lane_valid", ifc.lane_valid, 0);
    chk("rst_best_width", ifc.best_width, 0);
    chk("rst_pulses",     {ifc.fine_done, ifc.fine_failed}, 0);

    // All lanes pass 20..33 inside sweep 16..47.
    run_sweep(1, 2, uni(20, 33, 14, 16'hFFFF, 47), 0);

    // Lane3 two windows, lane5 equal-width tie keeps the earlier one.
    x = uni(20, 33, 14, 16'hFFFF, 47);
    x.s[3] = 30; x.e[3] = 39; x.w[3] = 10;
    x.s[5] = 17; x.e[5] = 22; x.w[5] = 6;
    run_sweep(2, 2, x, 0);

    // Lane0 never passes.
    x = uni(20, 33, 14, 16'hFFFE, 47);
    x.s[0] = 0; x.e[0] = 0; x.w[0] = 0;
    run_sweep(3, 2, x, 0);

    // Lane1 loses tap 25 to a single failed sample.
    x = uni(20, 33, 14, 16'hFFFF, 47);
    x.s[1] = 26; x.e[1] = 33; x.w[1] = 8;
    run_sweep(4, 2, x, 0);

    // Top coarse region: sweep clamps at 63, open run closed at finish, too narrow.
    run_sweep(5, 7, uni(60, 63, 4, 16'h0000, 63), 0);

    // No read responses: timeout abort.
    run_sweep(6, 2, uni(0, 0, 0, 16'h0000, 16), 0);

    // fine_start mid-sweep toward region 7 must be dropped.
    run_sweep(1, 2, uni(20, 33, 14, 16'hFFFF, 47), 60);

    // Reset mid-sweep clears everything and emits no pulse.
    mode = 1;
    @(negedge clk);
    ifc.coarse_sel = 3'd2;
    ifc.fine_start = 1'b1;
    @(negedge clk);
    ifc.fine_start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy",       ifc.busy,       0);
    chk("midrst_delay_tap",  ifc.delay_tap,  0);
    chk("midrst_lane_valid", ifc.lane_valid, 0);
    chk("midrst_best_start", ifc.best_start, 0);
    chk("midrst_best_width", ifc.best_width, 0);
    chk("midrst_pulses",     {ifc.fine_done, ifc.fine_failed}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("after_rst_idle", ifc.busy, 0);

    // Recovery after reset.
    run_sweep(1, 2, uni(20, 33, 14, 16'hFFFF, 47), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
